ws2812b_stream_arbiter: RTL and testbench
=========================================

# ws2812b_stream_arbiter

Shares one `ws2812b` serializer between `NREQ` pixel-stream requesters, such as the CPU register path and a character or scroll engine. Each requester owns the serializer for a whole frame, and grants rotate round-robin. The arbiter forwards pixels with a registered valid/ready handshake and tags the frame's last pixel with `latch`. It waits for the serializer to finish latching before it re-arbitrates.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 4096: stall limit in cycles. Used only with the timeout macro.

Ports (clock and reset first):
- `clk`, in, 1: single clock, 64 MHz nominal.
- `reset`, in, 1: asynchronous, active-high; all state clears immediately.
- `req_data`, in, NREQ*24: GRB pixel per requester. Slice i is `[24*i+23:24*i]`.
- `req_valid`, in, NREQ: requester i has a pixel.
- `req_last`, in, NREQ: the pixel is the last of its frame.
- `req_ready`, out, NREQ: pixel from requester i consumed this cycle.
- `grant`, out, NREQ: one-hot current owner; 0 when idle.
- `out_data`, out, 24: to serializer `data_in`.
- `out_valid`, out, 1: to serializer `valid`.
- `out_latch`, out, 1: to serializer `latch`, qualified by `out_valid`.
- `out_ready`, in, 1: from serializer `ready`.
- `busy`, out, 1: state is not IDLE.
- `timeout_flag`, out, 1: sticky; cleared only by reset.

## Operation
- State machine with states IDLE, STREAM and GAP.
- **Reset:** state=IDLE, round-robin pointer `rr`=0. All outputs are 0: `grant`, `req_ready`, `out_valid`, `out_latch`, `out_data`, `busy` and `timeout_flag`.
- **IDLE:**
  - If any `req_valid` is high, pick the first requester at or after `rr`, scanning upward and wrapping at NREQ.
  - Register the pick into `grant` and move to STREAM. `req_ready` stays 0 in IDLE.
- **STREAM:**
  - When `out_valid`=0 and the owner's `req_valid`=1, drive `req_ready[owner]`=1 combinationally in that cycle.
  - On the next edge, load `out_data`, set `out_latch`=`req_last[owner]` and set `out_valid`=1.
  - Non-owner `req_ready` is always 0.
- **Output register:**
  - `out_valid` holds, with `out_data` and `out_latch` stable, until a cycle with `out_valid`&`out_ready`.
  - `out_valid` clears on the next edge.
  - One beat is in flight at most; no new pixel is loaded in the accept cycle.
- **End of frame:** acceptance of a beat with `out_latch`=1 moves the FSM to GAP. `grant` holds through GAP.
- **GAP:**
  - Serializer contract: `ready` deasserts the cycle after an accept and reasserts after shift-out plus the latch period.
  - GAP ignores `out_ready` in its first cycle. From the second cycle onward, `out_ready`=1 moves the FSM to IDLE, sets `rr`=(owner+1) mod NREQ and clears `grant`.
- **Simultaneous events:**
  - Requests arriving during STREAM or GAP wait; requesters never see `req_ready` while not granted.
  - A requester that drops `req_valid` mid-frame simply stalls the frame.
- **Arithmetic:** `rr` is `$clog2(NREQ)` bits with explicit wrap at NREQ-1, not a power-of-two wrap.
- **Reset mid-frame:** everything aborts immediately and no `latch` is emitted. The strip holds the pixels already shifted; this is WS2812B low-line behaviour.

## Timing
- Request to grant: 1 cycle, i.e. `req_valid` sampled in IDLE gives `grant` on the next edge.
- Grant to first `req_ready`: same cycle as grant visible, if `req_valid` is still high.
- `req_ready` to `out_valid`: 1 cycle.
- Sustained throughput: one pixel per serializer accept cycle plus 1 cycle.
- Last accept to IDLE: at least 2 cycles, then gated by `out_ready`.
- All outputs are registered except `req_ready`, which is combinational from state, `out_valid` and `req_valid`.

## Configuration
- `WS2812B_ARB_TIMEOUT_EN` defined:
  - In STREAM, a counter increments each cycle that `out_valid`=0 and the owner's `req_valid`=0. It resets on every load.
  - Reaching TIMEOUT_CYCLES forces IDLE without latch, sets `timeout_flag`=1, advances `rr` past the owner and clears `grant`.
- Undefined: no counter exists, a stalled owner holds the grant indefinitely, and `timeout_flag` is tied 0.

## Structure
- Shared package `ws2812b_pkg`:
  - `PIXEL_W`=24.
  - State enum `arb_state_t` with values IDLE, STREAM and GAP.
  - `TIMEOUT_W` derived from `TIMEOUT_CYCLES`.
- One sub-module, `ws2812b_rr_pick`: combinational round-robin picker taking request vector and pointer, returning one-hot pick and any-request flag.

## Test plan
- **Single-owner frame:** requester 0 sends 3 pixels 0x002000, 0x200000, 0x000020 with last on the third. Expect 3 `out_valid` beats in order, `out_latch` only on the third, and `grant`=01 throughout, then 00 after `out_ready` returns.
- **Contention:** both requesters are valid in the same IDLE cycle with `rr`=0. Requester 0's full frame is followed by requester 1's frame, with no interleaved beats. The next contention grants requester 1 first.
- **Wrap:** NREQ=3 with only requesters 0 and 2 active and `rr`=2. Grant 2, then 0; `rr` wraps 2→0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with `out_valid`=1. `out_data` stays constant, `req_ready` stays 0 and no beat is lost.
- **Reset mid-frame:** assert `reset` after the 2nd of 5 beats. All outputs go 0 asynchronously and the FSM is in IDLE; after release, the first request is granted per `rr`=0.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** owner stalls after 1 beat. Exactly 16 stalled cycles later: `timeout_flag`=1, `grant`=0, and the other requester is granted next.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// ----------------------------------------------------------------------------
// ws2812b_pkg
// Shared types and constants for the WS2812B pixel-stream arbiter slice.
//   PIXEL_W     : width of one GRB pixel
//   arb_state_t : arbiter FSM states
//   timeout_w() : counter width needed to count up to a given stall limit
// ----------------------------------------------------------------------------
package ws2812b_pkg;

   localparam int unsigned PIXEL_W            = 24;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } arb_state_t;

   // Bits needed to hold values 0..cycles
   function automatic int unsigned timeout_w(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

   localparam int unsigned TIMEOUT_W = timeout_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/ws2812b_rr_pick.sv
// ----------------------------------------------------------------------------
// ws2812b_rr_pick
// Combinational round-robin picker: first asserted request at or after the
// pointer, scanning upward and wrapping at NREQ.
//   req_i  : request vector
//   ptr_i  : round-robin start index (always < NREQ)
//   pick_o : one-hot winner, 0 when no request
//   any_o  : at least one request present
// ----------------------------------------------------------------------------
module ws2812b_rr_pick #(
   parameter  int unsigned NREQ  = 2,
   localparam int unsigned PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  pick_o,
   output logic             any_o
);

   always_comb begin
      int unsigned idx;
      logic        found;
      pick_o = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // explicit wrap at NREQ, which need not be a power of two
         idx = 32'(ptr_i) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_i[PTR_W'(idx)]) begin
            pick_o[PTR_W'(idx)] = 1'b1;
            found               = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/ws2812b_stream_arbiter.sv
// ----------------------------------------------------------------------------
// ws2812b_stream_arbiter
// Shares one WS2812B serializer between NREQ pixel-stream requesters. A granted
// requester owns the serializer for a whole frame; ownership rotates
// round-robin and is only re-arbitrated once the serializer has finished
// latching the frame.
//   clk, reset           : clock, asynchronous active-high reset
//   req_data/valid/last  : per-requester pixel stream (slice i = [24*i+23:24*i])
//   req_ready            : combinational consume strobe, owner only
//   grant                : one-hot owner, 0 when idle
//   out_data/valid/latch : registered beat towards the serializer
//   out_ready            : serializer ready
//   busy                 : FSM not idle
//   timeout_flag         : sticky stall-timeout indicator
// Optional stall timeout enabled by defining WS2812B_ARB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module ws2812b_stream_arbiter
   import ws2812b_pkg::*;
#(
   parameter int unsigned NREQ           = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ*PIXEL_W-1:0] req_data,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         grant,
   output logic [PIXEL_W-1:0]      out_data,
   output logic                    out_valid,
   output logic                    out_latch,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    timeout_flag
);

   localparam int unsigned PTR_W = $clog2(NREQ);
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES == TIMEOUT_CYCLES_DEF) ?
                                   TIMEOUT_W : timeout_w(TIMEOUT_CYCLES);

   arb_state_t          state_q, state_d;
   logic [PTR_W-1:0]    rr_q, rr_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [PIXEL_W-1:0]  out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_latch_q, out_latch_d;
   logic                busy_q, busy_d;
   logic                gap_first_q, gap_first_d;

   logic [NREQ-1:0]     pick;
   logic                pick_any;
   logic [PIXEL_W-1:0]  owner_data;
   logic [PTR_W-1:0]    owner_idx;
   logic [PTR_W-1:0]    rr_adv;
   logic                owner_valid;
   logic                owner_last;
   logic                load;
   logic                accept;

`ifdef WS2812B_ARB_TIMEOUT_EN
   logic [TO_W-1:0]     stall_q, stall_d;
   logic                timeout_q, timeout_d;
`else
   logic                unused_cfg;
   assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(TO_W)};
`endif

   ws2812b_rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i  (req_valid),
      .ptr_i  (rr_q),
      .pick_o (pick),
      .any_o  (pick_any)
   );

   // Owner-side mux driven by the one-hot grant
   always_comb begin
      owner_data = '0;
      owner_idx  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            owner_data = owner_data | req_data[i*PIXEL_W +: PIXEL_W];
            owner_idx  = PTR_W'(i);
         end
      end
   end

   assign owner_valid = |(grant_q & req_valid);
   assign owner_last  = |(grant_q & req_last);
   assign rr_adv      = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + PTR_W'(1);

   // Only one beat in flight: the owner is consumed only when the output register is empty
   assign load      = (state_q == STREAM) && !out_valid_q && owner_valid;
   assign accept    = out_valid_q && out_ready;
   assign req_ready = ((state_q == STREAM) && !out_valid_q) ? (grant_q & req_valid) : '0;

   // Next-state and output-register logic
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      grant_d     = grant_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_latch_d = out_latch_q;
      gap_first_d = gap_first_q;
`ifdef WS2812B_ARB_TIMEOUT_EN
      stall_d     = stall_q;
      timeout_d   = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (load) begin
               out_data_d  = owner_data;
               out_latch_d = owner_last;
               out_valid_d = 1'b1;
`ifdef WS2812B_ARB_TIMEOUT_EN
               stall_d     = '0;
`endif
            end else if (accept) begin
               out_valid_d = 1'b0;
               out_latch_d = 1'b0;
               if (out_latch_q) begin
                  state_d     = GAP;
                  gap_first_d = 1'b1;
               end
`ifdef WS2812B_ARB_TIMEOUT_EN
            end else if (!out_valid_q) begin
               // register empty and owner silent: a stalled cycle
               if (stall_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d   = IDLE;
                  grant_d   = '0;
                  rr_d      = rr_adv;
                  timeout_d = 1'b1;
                  stall_d   = '0;
               end else begin
                  stall_d = stall_q + TO_W'(1);
               end
`endif
            end
         end
         GAP: begin
            // serializer ready is stale in the first GAP cycle
            if (gap_first_q) begin
               gap_first_d = 1'b0;
            end else if (out_ready) begin
               state_d = IDLE;
               rr_d    = rr_adv;
               grant_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         grant_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_latch_q <= 1'b0;
         busy_q      <= 1'b0;
         gap_first_q <= 1'b0;
`ifdef WS2812B_ARB_TIMEOUT_EN
         stall_q     <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         grant_q     <= grant_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_latch_q <= out_latch_d;
         busy_q      <= busy_d;
         gap_first_q <= gap_first_d;
`ifdef WS2812B_ARB_TIMEOUT_EN
         stall_q     <= stall_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_latch = out_latch_q;
   assign busy      = busy_q;
`ifdef WS2812B_ARB_TIMEOUT_EN
   assign timeout_flag = timeout_q;
`else
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ws2812b_stream_arbiter
// Randomized scoreboard bench. Frames are queued per requester up front; a
// frame-level round-robin model derives the expected beat order, and a
// negedge monitor pops and compares every accepted beat plus per-cycle rules.
// ----------------------------------------------------------------------------
module tb_ws2812b_stream_arbiter;

   localparam int NREQ = 3;
   localparam int PW   = 24;
   localparam int TOC  = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ*PW-1:0]   req_data;
   logic [NREQ-1:0]      req_valid, req_last, req_ready, grant;
   logic [PW-1:0]        out_data;
   logic                 out_valid, out_latch, out_ready, busy, timeout_flag;

   ws2812b_stream_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TOC)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_data     (req_data),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_latch    (out_latch),
      .out_ready    (out_ready),
      .busy         (busy),
      .timeout_flag (timeout_flag)
   );

   always #5 clk = ~clk;

   typedef struct {logic [PW-1:0] data; logic last;} pix_t;
   typedef struct {logic [PW-1:0] data; logic last; int owner;} beat_t;

   pix_t            src_q[NREQ][$];
   beat_t           exp_q[$];
   int              checks = 0;
   int              failures = 0;
   int              model_rr = 0;
   bit              run = 1'b0;
   bit              stall_en = 1'b0;
   int              rdy_pct = 100;
   int              bp_hold = 0;
   bit [NREQ-1:0]   block_after = '0;
   bit [NREQ-1:0]   blocked = '0;
   int              beats_seen = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic add_pixel(input int r, input logic [PW-1:0] d, input logic l);
      pix_t p;
      p.data = d;
      p.last = l;
      src_q[r].push_back(p);
   endtask

   task automatic add_rand_frame(input int r, input int n);
      for (int k = 0; k < n; k++) add_pixel(r, PW'($urandom), (k == n - 1));
   endtask

   function automatic bit any_src();
      for (int i = 0; i < NREQ; i++)
         if (src_q[i].size() > 0 && !blocked[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Frame-level round robin: whole frames, first pending requester at/after rr
   task automatic build_expected();
      pix_t  cp[NREQ][$];
      pix_t  p;
      beat_t b;
      int    pick;
      int    j;
      for (int i = 0; i < NREQ; i++) cp[i] = src_q[i];
      while (1) begin
         pick = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (model_rr + k) % NREQ;
            if (pick < 0 && cp[j].size() > 0) pick = j;
         end
         if (pick < 0) break;
         p.last = 1'b0;
         while (!p.last && cp[pick].size() > 0) begin
            p = cp[pick].pop_front();
            b.data = p.data; b.last = p.last; b.owner = pick;
            exp_q.push_back(b);
         end
         model_rr = (pick + 1) % NREQ;
      end
   endtask

   // Requester and serializer driver: inputs change 1 time unit after posedge
   initial begin : driver
      logic [NREQ-1:0] fire;
      bit              drop;
      req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
               void'(src_q[i].pop_front());
               if (block_after[i]) blocked[i] = 1'b1;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            drop = stall_en && grant[i] && ($urandom_range(0, 3) == 0);
            if (run && src_q[i].size() > 0 && !blocked[i] && !drop) begin
               req_valid[i]          = 1'b1;
               req_data[i*PW +: PW]  = src_q[i][0].data;
               req_last[i]           = src_q[i][0].last;
            end else begin
               req_valid[i]          = 1'b0;
               req_data[i*PW +: PW]  = PW'($urandom);
               req_last[i]           = 1'($urandom_range(0, 1));
            end
         end
         if (bp_hold > 0) begin
            out_ready = 1'b0;
            if (out_valid) bp_hold--;
         end else begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
         end
      end
   end

   // Monitor: per-cycle rules plus scoreboard pop on each accepted beat
   logic [PW-1:0]   prev_data;
   logic            prev_latch;
   bit              prev_hold = 1'b0;
   bit              prev_rdy = 1'b0;
   bit              in_gap = 1'b0;
   int              gap_age = 0;
   logic [NREQ-1:0] gap_owner;

   always @(negedge clk) begin : monitor
      beat_t           e;
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] oh;
      if (reset) begin
         prev_hold = 1'b0; prev_rdy = 1'b0; in_gap = 1'b0;
      end else begin
         check(busy == (grant != '0), "busy_vs_grant", 32'(busy), 32'(grant));
         check($onehot0(grant), "grant_onehot", 32'(grant), 32'(grant));
`ifndef WS2812B_ARB_TIMEOUT_EN
         check(timeout_flag == 1'b0, "timeout_tied", 32'(timeout_flag), 32'd0);
`endif
         exp_rdy = (!in_gap && !out_valid) ? (grant & req_valid) : '0;
         check(req_ready == exp_rdy, "req_ready", 32'(req_ready), 32'(exp_rdy));
         if (prev_hold)
            check(out_valid && out_data == prev_data && out_latch == prev_latch,
                  "hold_stable", 32'(out_data), 32'(prev_data));
         if (in_gap) begin
            gap_age++;
            if (grant == '0) begin
               check(prev_rdy && gap_age >= 3, "gap_exit", 32'(gap_age), 32'd3);
               in_gap = 1'b0;
            end else begin
               check(grant == gap_owner, "gap_owner", 32'(grant), 32'(gap_owner));
            end
         end
         if (out_valid && out_ready) begin
            check(exp_q.size() != 0, "beat_expected", 32'(out_data), 32'd0);
            if (exp_q.size() != 0) begin
               e  = exp_q.pop_front();
               oh = '0;
               oh[e.owner] = 1'b1;
               check(out_data == e.data, "beat_data", 32'(out_data), 32'(e.data));
               check(out_latch == e.last, "beat_latch", 32'(out_latch), 32'(e.last));
               check(grant == oh, "beat_owner", 32'(grant), 32'(oh));
            end
            beats_seen++;
            if (out_latch) begin
               in_gap = 1'b1; gap_age = 0; gap_owner = grant;
            end
         end
         prev_hold  = out_valid && !out_ready;
         prev_data  = out_data;
         prev_latch = out_latch;
         prev_rdy   = out_ready;
      end
   end

   task automatic run_phase(input string name);
      int n;
      build_expected();
      run = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || any_src() || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(n < 3000, {name, "_done"}, 32'(n), 32'd3000);
      run = 1'b0;
      bp_hold = 0;
      @(negedge clk);
      check(grant == '0 && !out_valid, {name, "_idle"}, 32'(grant), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check(grant == '0,        {name, "_grant"},     32'(grant), 32'd0);
      check(req_ready == '0,    {name, "_req_ready"}, 32'(req_ready), 32'd0);
      check(out_valid == 1'b0,  {name, "_out_valid"}, 32'(out_valid), 32'd0);
      check(out_latch == 1'b0,  {name, "_out_latch"}, 32'(out_latch), 32'd0);
      check(out_data == '0,     {name, "_out_data"},  32'(out_data), 32'd0);
      check(busy == 1'b0,       {name, "_busy"},      32'(busy), 32'd0);
      check(timeout_flag == 1'b0, {name, "_tflag"},   32'(timeout_flag), 32'd0);
   endtask

   initial begin : main
      int   n;
      pix_t p;
      beat_t b;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // single-owner frame
      add_pixel(0, 24'h002000, 1'b0);
      add_pixel(0, 24'h200000, 1'b0);
      add_pixel(0, 24'h000020, 1'b1);
      rdy_pct = 100;
      run_phase("single");

      // requester 1 alone moves rr to 2, then 0 and 2 contend: 2 first, rr wraps
      add_rand_frame(1, 2);
      run_phase("solo1");
      add_rand_frame(0, 2);
      add_rand_frame(2, 3);
      run_phase("wrap");

      // rr back to 0, then contention with interleaved frames and random stalls
      add_rand_frame(2, 1);
      run_phase("solo2");
      add_rand_frame(0, 3);
      add_rand_frame(0, 2);
      add_rand_frame(1, 4);
      rdy_pct = 60; stall_en = 1'b1;
      run_phase("contend");

      // backpressure: 10 cycles of out_ready=0 with a beat pending
      stall_en = 1'b0; rdy_pct = 100; bp_hold = 10;
      add_rand_frame(1, 4);
      run_phase("backpressure");

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NREQ; i++)
            for (int f = 0; f < int'($urandom_range(0, 2)); f++)
               add_rand_frame(i, int'($urandom_range(1, 5)));
         rdy_pct = int'($urandom_range(40, 100));
         stall_en = 1'b1;
         run_phase("random");
      end
      stall_en = 1'b0; rdy_pct = 100;

      // reset mid-frame: rr is 1 beforehand, requester 1 aborted after 2 beats
      add_rand_frame(0, 1);
      run_phase("pre_reset");
      add_rand_frame(1, 5);
      for (int k = 0; k < 2; k++) begin
         p = src_q[1][k];
         b.data = p.data; b.last = p.last; b.owner = 1;
         exp_q.push_back(b);
      end
      beats_seen = 0;
      run = 1'b1;
      n = 0;
      while (beats_seen < 2 && n < 200) begin @(negedge clk); n++; end
      check(n < 200, "reset_wait", 32'(n), 32'd200);
      @(posedge clk);
      #2;
      reset = 1'b1;
      run = 1'b0;
      #1;
      check_all_zero("async_reset");
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      exp_q.delete();
      model_rr = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      add_rand_frame(1, 2);
      add_rand_frame(0, 2);
      run_phase("post_reset");

`ifdef WS2812B_ARB_TIMEOUT_EN
      // owner 0 stalls after its first beat; requester 1 takes over
      add_rand_frame(0, 3);
      add_rand_frame(1, 2);
      p = src_q[0][0];
      b.data = p.data; b.last = p.last; b.owner = 0;
      exp_q.push_back(b);
      for (int k = 0; k < 2; k++) begin
         p = src_q[1][k];
         b.data = p.data; b.last = p.last; b.owner = 1;
         exp_q.push_back(b);
      end
      block_after[0] = 1'b1;
      run = 1'b1;
      n = 0;
      while (!(out_valid && out_ready && grant == 3'b001) && n < 200) begin @(negedge clk); n++; end
      check(n < 200, "to_first_beat", 32'(n), 32'd200);
      n = 0;
      @(negedge clk);
      while (grant == 3'b001 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(n == TOC, "to_stall_cycles", 32'(n), 32'(TOC));
      check(timeout_flag == 1'b1, "to_flag", 32'(timeout_flag), 32'd1);
      check(grant == '0, "to_grant_clear", 32'(grant), 32'd0);
      check(out_latch == 1'b0, "to_no_latch", 32'(out_latch), 32'd0);
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin @(negedge clk); n++; end
      check(n < 500, "to_done", 32'(n), 32'd500);
      check(timeout_flag == 1'b1, "to_sticky", 32'(timeout_flag), 32'd1);
      run = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
